// File: rtl/edge_monitor_if.sv
// Bundle between the flop-output monitor and its observer.
// master drives the sampled bit and clear; slave is the monitor itself.
interface edge_monitor_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned RUN_W = 6
);
  logic             d;
  logic             clear;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] rise_count;
  logic [CNT_W-1:0] fall_count;
  logic             ovf;
  logic [RUN_W-1:0] run_len;
  logic             stable;

  modport master (
    output d, clear,
    input  rise, fall, rise_count, fall_count, ovf, run_len, stable
  );

  modport slave (
    input  d, clear,
    output rise, fall, rise_count, fall_count, ovf, run_len, stable
  );
endinterface

// File: rtl/edge_monitor.sv
// Edge monitor for a single-bit flop output: rise/fall pulses, edge counters,
// sticky overflow and run-length. Define EDGE_MONITOR_SATURATE_EN to saturate counters.
module edge_monitor #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned RUN_W      = 6,
  parameter int unsigned STABLE_CYC = 4
) (
  input logic          clk,
  input logic          reset,
  edge_monitor_if.slave mon
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  typedef enum logic {PRIME, TRACK} state_t;

  state_t           state, state_nxt;
  logic             d_q, d_q_nxt;
  logic             rise_r, rise_nxt;
  logic             fall_r, fall_nxt;
  logic [CNT_W-1:0] rise_cnt, rise_cnt_nxt;
  logic [CNT_W-1:0] fall_cnt, fall_cnt_nxt;
  logic             ovf_r, ovf_nxt;
  logic [RUN_W-1:0] run_r, run_nxt;
  logic             rise_hit, fall_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PRIME;
      d_q      <= 1'b0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
      rise_cnt <= '0;
      fall_cnt <= '0;
      ovf_r    <= 1'b0;
      run_r    <= '0;
    end else begin
      state    <= state_nxt;
      d_q      <= d_q_nxt;
      rise_r   <= rise_nxt;
      fall_r   <= fall_nxt;
      rise_cnt <= rise_cnt_nxt;
      fall_cnt <= fall_cnt_nxt;
      ovf_r    <= ovf_nxt;
      run_r    <= run_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    d_q_nxt      = d_q;
    rise_nxt     = 1'b0;
    fall_nxt     = 1'b0;
    rise_cnt_nxt = rise_cnt;
    fall_cnt_nxt = fall_cnt;
    ovf_nxt      = ovf_r;
    run_nxt      = run_r;
    rise_hit     = 1'b0;
    fall_hit     = 1'b0;

    case (state)
      PRIME: begin
        state_nxt = TRACK;
        d_q_nxt   = mon.d;
        run_nxt   = RUN_W'(1);
      end
      TRACK: begin
        d_q_nxt  = mon.d;
        rise_hit = mon.d & ~d_q;
        fall_hit = ~mon.d & d_q;
        rise_nxt = rise_hit;
        fall_nxt = fall_hit;
        if (mon.d != d_q)
          run_nxt = RUN_W'(1);
        else if (run_r != RUN_MAX)
          run_nxt = run_r + RUN_W'(1);
      end
      default: state_nxt = PRIME;
    endcase

    // A clear coinciding with an edge still records that edge as count 1.
    if (mon.clear) begin
      rise_cnt_nxt = rise_hit ? CNT_W'(1) : '0;
      fall_cnt_nxt = fall_hit ? CNT_W'(1) : '0;
      ovf_nxt      = 1'b0;
    end else begin
      if (rise_hit) begin
        if (rise_cnt == CNT_MAX) begin
          ovf_nxt = 1'b1;
`ifdef EDGE_MONITOR_SATURATE_EN
          rise_cnt_nxt = CNT_MAX;
`else
          rise_cnt_nxt = '0;
`endif
        end else begin
          rise_cnt_nxt = rise_cnt + CNT_W'(1);
        end
      end
      if (fall_hit) begin
        if (fall_cnt == CNT_MAX) begin
          ovf_nxt = 1'b1;
`ifdef EDGE_MONITOR_SATURATE_EN
          fall_cnt_nxt = CNT_MAX;
`else
          fall_cnt_nxt = '0;
`endif
        end else begin
          fall_cnt_nxt = fall_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign mon.rise       = rise_r;
  assign mon.fall       = fall_r;
  assign mon.rise_count = rise_cnt;
  assign mon.fall_count = fall_cnt;
  assign mon.ovf        = ovf_r;
  assign mon.run_len    = run_r;
  assign mon.stable     = (run_r >= RUN_W'(STABLE_CYC));

endmodule

// File: tb/tb_edge_monitor.sv
// Scoreboard bench for edge_monitor: driver pushes model predictions, monitor pops and compares.
module tb_edge_monitor;

  localparam int unsigned CNT_W      = 2;
  localparam int unsigned RUN_W      = 6;
  localparam int unsigned STABLE_CYC = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int RUN_MAX = (1 << RUN_W) - 1;

  typedef struct {
    bit rise;
    bit fall;
    int rc;
    int fc;
    bit ovf;
    int run;
    bit stable;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;
  exp_t exp_q[$];

  // reference state: plain integers, spec rules applied directly
  bit m_primed = 0;
  bit m_prev   = 0;
  int m_rc = 0, m_fc = 0, m_run = 0;
  bit m_ovf = 0, m_rise = 0, m_fall = 0;

  edge_monitor_if #(.CNT_W(CNT_W), .RUN_W(RUN_W)) ifc ();

  edge_monitor #(.CNT_W(CNT_W), .RUN_W(RUN_W), .STABLE_CYC(STABLE_CYC)) dut (
    .clk  (clk),
    .reset(reset),
    .mon  (ifc)
  );

  always #5 clk = ~clk;

  function automatic void bump(inout int cnt, inout bit ovf);
    int n;
    n = cnt + 1;
    if (n > CNT_MAX) begin
      ovf = 1;
`ifdef EDGE_MONITOR_SATURATE_EN
      n = CNT_MAX;
`else
      n = n % (CNT_MAX + 1);
`endif
    end
    cnt = n;
  endfunction

  function automatic void model(input bit r, input bit c, input bit dv);
    if (r) begin
      m_primed = 0; m_prev = 0; m_rise = 0; m_fall = 0;
      m_rc = 0; m_fc = 0; m_ovf = 0; m_run = 0;
      return;
    end
    m_rise = 0;
    m_fall = 0;
    if (!m_primed) begin
      m_primed = 1;
      m_run = 1;
    end else begin
      m_rise = (dv == 1 && m_prev == 0);
      m_fall = (dv == 0 && m_prev == 1);
      m_run  = (dv != m_prev) ? 1 : ((m_run + 1 > RUN_MAX) ? RUN_MAX : m_run + 1);
    end
    m_prev = dv;
    if (c) begin
      m_rc = 0; m_fc = 0; m_ovf = 0;
    end
    if (m_rise) bump(m_rc, m_ovf);
    if (m_fall) bump(m_fc, m_ovf);
  endfunction

  task automatic step(input bit r, input bit c, input bit dv);
    exp_t e;
    @(negedge clk);
    reset   = r;
    ifc.clear = c;
    ifc.d   = dv;
    model(r, c, dv);
    e.rise = m_rise; e.fall = m_fall; e.rc = m_rc; e.fc = m_fc;
    e.ovf = m_ovf; e.run = m_run; e.stable = (m_run >= int'(STABLE_CYC));
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
  endtask

  // monitor: outputs are valid every cycle, compare 1 time unit after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("rise",       int'(ifc.rise),       int'(e.rise));
        cmp("fall",       int'(ifc.fall),       int'(e.fall));
        cmp("rise_count", int'(ifc.rise_count), e.rc);
        cmp("fall_count", int'(ifc.fall_count), e.fc);
        cmp("ovf",        int'(ifc.ovf),        int'(e.ovf));
        cmp("run_len",    int'(ifc.run_len),    e.run);
        cmp("stable",     int'(ifc.stable),     int'(e.stable));
      end
    end
  end

  initial begin
    bit dv;
    ifc.d = 1'b0;
    ifc.clear = 1'b0;

    // reset priming with don't-care data, then d held high
    for (int i = 0; i < 3; i++) step(1, 0, 1'($urandom));
    for (int i = 0; i < 6; i++) step(0, 0, 1);

    // basic edges after priming low
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0); step(0, 0, 1); step(0, 0, 1); step(0, 0, 0); step(0, 0, 1);

    // toggle every cycle
    dv = 1;
    for (int i = 0; i < 10; i++) begin
      dv = ~dv;
      step(0, 0, dv);
    end

    // overflow: clear, then five rising edges
    step(0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1);
      step(0, 0, 0);
    end

    // clear collision on a rising edge
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 1, 1);
    step(0, 0, 1);

    // reset mid-stream, then d falls right after reset
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    step(1, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 1);

    // long hold to reach run_len saturation
    for (int i = 0; i < RUN_MAX + 6; i++) step(0, 0, 1);

    // randomized traffic with occasional clear and reset
    dv = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 2) == 0) dv = ~dv;
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 15) == 0), dv);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
